io_responder: RTL and testbench

//  Bus responder for the Risc32 memory-mapped IO port: decodes io_address and serves io_read_en/io_write_en.

---
 rtl/io_responder_if.sv | 43 ++++
 rtl/io_responder.sv | 201 ++++++++++++++++++++
 tb/tb_io_responder.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_responder_if.sv
// ---------------------------------------------------------------------------
// io_responder_if
//   Memory-mapped IO bus between the Risc32 core and the io_responder block.
//
//   Signals:
//     io_address      byte address from the processor
//     io_write_value  store data from the processor
//     io_read_value   load data back to the processor (combinational)
//     io_write_en     one-cycle store strobe
//     io_read_en      load strobe
//
//   Handshake: there is no valid/ready on this bus. A store happens on
//   every rising clock edge where io_write_en is high. A load is answered
//   in the same cycle that io_read_en is high, with no wait states. A
//   load has no side effects.
//
//   Modports:
//     master  processor side (drives address/data/strobes)
//     slave   responder side (drives io_read_value)
// ---------------------------------------------------------------------------
interface io_responder_if;
    logic [31:0] io_address;
    logic [31:0] io_write_value;
    logic [31:0] io_read_value;
    logic        io_write_en;
    logic        io_read_en;

    modport master (
        output io_address,
        output io_write_value,
        output io_write_en,
        output io_read_en,
        input  io_read_value
    );

    modport slave (
        input  io_address,
        input  io_write_value,
        input  io_write_en,
        input  io_read_en,
        output io_read_value
    );
endinterface

// File: rtl/io_responder.sv
// ---------------------------------------------------------------------------
// io_responder
//   Bus responder for the Risc32 memory-mapped IO port. It decodes
//   IO_BASE..IO_BASE+0x1F (word-aligned) and holds these resources:
//     - a GPIO output register
//     - a two-flop synchronised GPIO input
//     - a 32-bit timer with a compare register, a sticky match flag and an irq
//     - a FIFO_D-entry byte TX FIFO, drained by a valid/ready consumer
//
//   Ports:
//     clk       system clock; all state changes on the rising edge
//     reset_n   asynchronous active-low reset
//     io        slave side of io_responder_if (address/data/strobes in,
//               read data out)
//     gpio_in   asynchronous external inputs
//     gpio_out  registered GPIO outputs
//     tx_data   FIFO head byte (0 when empty)
//     tx_valid  FIFO non-empty
//     tx_ready  consumer takes the head at a clock edge when tx_valid is high
//     irq       registered STATUS.match & CTRL.irq_en
//
//   Register map (byte offset):
//     0x00 GPIO_OUT RW   0x04 GPIO_IN RO   0x08 TIMER RW   0x0C CMP RW
//     0x10 CTRL RW (b0 timer_en, b1 irq_en)
//     0x14 STATUS (b0 match W1C, b1 full, b2 empty, b3 ovf W1C, b[6:4] count)
//     0x18 TX_DATA WO (reads 0)   0x1C reserved
// ---------------------------------------------------------------------------
module io_responder #(
    parameter logic [31:0] IO_BASE = 32'h0000_1000,
    parameter int          GPIO_W  = 8,
    parameter int          FIFO_D  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    io_responder_if.slave     io,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              irq
);

    localparam int PTR_W = $clog2(FIFO_D);
    localparam int CNT_W = $clog2(FIFO_D + 1);

    localparam logic [2:0] OFF_GPIO_OUT = 3'd0;
    localparam logic [2:0] OFF_GPIO_IN  = 3'd1;
    localparam logic [2:0] OFF_TIMER    = 3'd2;
    localparam logic [2:0] OFF_CMP      = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_STATUS   = 3'd5;
    localparam logic [2:0] OFF_TX_DATA  = 3'd6;

    // State registers
    logic [GPIO_W-1:0] sync1_q, sync2_q;
    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [31:0]       timer_q, timer_d;
    logic [31:0]       cmp_q, cmp_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              match_q, match_d;
    logic              ovf_q, ovf_d;
    logic              irq_q, irq_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [7:0]        mem_q [FIFO_D];

    // Decode
    logic        hit;
    logic [2:0]  offset;
    logic        wr_hit;
    logic [31:0] wdata;
    logic        fifo_full, fifo_empty;
    logic        push, pop, push_ok;
    logic        match_set;
    logic [31:0] status_w;
    logic [31:0] rd_data;

    // Byte-lane bits of the address are ignored on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^io.io_address[1:0];

    assign hit    = (io.io_address[31:5] == IO_BASE[31:5]);
    assign offset = io.io_address[4:2];
    assign wr_hit = io.io_write_en & hit;
    assign wdata  = io.io_write_value;

    assign fifo_full  = (count_q == CNT_W'(FIFO_D));
    assign fifo_empty = (count_q == '0);

    assign tx_valid = ~fifo_empty;
    // The head slot is never overwritten while occupied: writes go to
    // wr_ptr, which only equals rd_ptr when empty or full, and a push into a
    // full FIFO is accepted only together with a pop.
    assign tx_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
    assign gpio_out = gpio_out_q;
    assign irq      = irq_q;

    assign pop       = tx_valid & tx_ready;
    assign push      = wr_hit && (offset == OFF_TX_DATA);
    assign push_ok   = push && (!fifo_full || pop);
    // Compare against the pre-increment timer value.
    assign match_set = ctrl_q[0] && (timer_q == cmp_q);

    always_comb begin
        status_w              = '0;
        status_w[0]           = match_q;
        status_w[1]           = fifo_full;
        status_w[2]           = fifo_empty;
        status_w[3]           = ovf_q;
        status_w[4 +: CNT_W]  = count_q;
    end

    // Read mux: pure combinational, no side effects.
    always_comb begin
        rd_data = '0;
        if (io.io_read_en && hit) begin
            case (offset)
                OFF_GPIO_OUT: rd_data = 32'(gpio_out_q);
                OFF_GPIO_IN:  rd_data = 32'(sync2_q);
                OFF_TIMER:    rd_data = timer_q;
                OFF_CMP:      rd_data = cmp_q;
                OFF_CTRL:     rd_data = {30'b0, ctrl_q};
                OFF_STATUS:   rd_data = status_w;
                default:      rd_data = '0;
            endcase
        end
    end
    assign io.io_read_value = rd_data;

    // Next-state logic
    always_comb begin
        gpio_out_d = gpio_out_q;
        timer_d    = timer_q;
        cmp_d      = cmp_q;
        ctrl_d     = ctrl_q;
        match_d    = match_q;
        ovf_d      = ovf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (wr_hit && offset == OFF_GPIO_OUT) gpio_out_d = wdata[GPIO_W-1:0];
        if (wr_hit && offset == OFF_CMP)      cmp_d      = wdata;
        if (wr_hit && offset == OFF_CTRL)     ctrl_d     = wdata[1:0];

        // A software write to TIMER wins over the increment.
        if (wr_hit && offset == OFF_TIMER) timer_d = wdata;
        else if (ctrl_q[0])                timer_d = timer_q + 32'd1;

        // For the sticky flags, a set wins over a W1C in the same cycle.
        if (wr_hit && offset == OFF_STATUS && wdata[0]) match_d = 1'b0;
        if (match_set)                                 match_d = 1'b1;
        if (wr_hit && offset == OFF_STATUS && wdata[3]) ovf_d   = 1'b0;
        if (push && fifo_full && !pop)                 ovf_d   = 1'b1;

        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push_ok && pop) count_d = count_q - CNT_W'(1);

        irq_d = match_d & ctrl_d[1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            gpio_out_q <= '0;
            timer_q    <= '0;
            cmp_q      <= 32'hFFFF_FFFF;
            ctrl_q     <= '0;
            match_q    <= 1'b0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            gpio_out_q <= gpio_out_d;
            timer_q    <= timer_d;
            cmp_q      <= cmp_d;
            ctrl_q     <= ctrl_d;
            match_q    <= match_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage needs no reset; empty/valid come from count_q.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata[7:0];
    end

endmodule

// File: tb/tb_io_responder.sv
// ---------------------------------------------------------------------------
// tb_io_responder
//   Testbench for io_responder. Expected values come from simple rules:
//   timer = start + elapsed cycles, the FIFO is modelled as a byte queue of
//   capacity 4, and the sticky flags are modelled as plain bits.
// ---------------------------------------------------------------------------
module tb_io_responder;

    localparam logic [31:0] A_GPIO_OUT = 32'h0000_1000;
    localparam logic [31:0] A_GPIO_IN  = 32'h0000_1004;
    localparam logic [31:0] A_TIMER    = 32'h0000_1008;
    localparam logic [31:0] A_CMP      = 32'h0000_100C;
    localparam logic [31:0] A_CTRL     = 32'h0000_1010;
    localparam logic [31:0] A_STATUS   = 32'h0000_1014;
    localparam logic [31:0] A_TX_DATA  = 32'h0000_1018;
    localparam logic [31:0] A_RSVD     = 32'h0000_101C;
    localparam int          DEPTH      = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] gpio_in = 8'h00;
    logic [7:0] gpio_out;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       irq;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic       m_ovf;

    io_responder_if bus ();

    io_responder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .io       (bus),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .irq      (irq)
    );

    // Clock
    always #5 clk = ~clk;

    // Driver tasks. wr: one store on the next rising edge, returns 1 ns after it.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.io_address     = addr;
        bus.io_write_value = data;
        bus.io_write_en    = 1'b1;
        @(posedge clk);
        #1;
        bus.io_write_en    = 1'b0;
    endtask

    // rd: combinational load sampled in the current low phase.
    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus.io_address = addr;
        bus.io_read_en = 1'b1;
        #1;
        data = bus.io_read_value;
        bus.io_read_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (gpio_out !== 8'h00) begin failures++; $display("FAIL reset_gpio_out got=%h exp=00", gpio_out); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        rd(A_STATUS, v);
        checks++; if (v !== 32'h0000_0004) begin failures++; $display("FAIL reset_status got=%h exp=00000004", v); end
        rd(A_TIMER, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_timer got=%h exp=0", v); end
        rd(A_CMP, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp got=%h exp=ffffffff", v); end
        reset_n = 1'b1;
        @(negedge clk);
        rd(A_CTRL, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", v); end
    endtask

    task automatic test_gpio();
        logic [31:0] v;
        logic [7:0]  val, old_in, new_in;
        for (int i = 0; i < 4; i++) begin
            val = (i == 0) ? 8'hA5 : 8'($urandom);
            wr(A_GPIO_OUT, {24'($urandom), val});
            checks++; if (gpio_out !== val) begin failures++; $display("FAIL gpio_out got=%h exp=%h", gpio_out, val); end
            @(negedge clk);
            rd(A_GPIO_OUT | 32'($urandom_range(0, 3)), v);
            checks++; if (v !== {24'b0, val}) begin failures++; $display("FAIL gpio_out_rd got=%h exp=%h", v, val); end
        end
        // Writes and reads outside the decoded window have no effect.
        wr(32'h0000_2000, ~{24'b0, val});
        checks++; if (gpio_out !== val) begin failures++; $display("FAIL gpio_miss_wr got=%h exp=%h", gpio_out, val); end
        @(negedge clk);
        rd(32'h0000_2000, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL miss_rd got=%h exp=0", v); end
        rd(A_RSVD, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL rsvd_rd got=%h exp=0", v); end
        bus.io_address = A_GPIO_OUT;
        bus.io_read_en = 1'b0;
        #1;
        checks++; if (bus.io_read_value !== 32'h0) begin failures++; $display("FAIL no_read_en got=%h exp=0", bus.io_read_value); end
        // Synchroniser: the new value is visible after exactly two edges.
        old_in = gpio_in;
        for (int i = 0; i < 4; i++) begin
            new_in = (i == 0) ? 8'h3C : (old_in ^ 8'($urandom_range(1, 255)));
            @(negedge clk);
            gpio_in = new_in;
            @(posedge clk);
            @(negedge clk);
            rd(A_GPIO_IN, v);
            checks++; if (v !== {24'b0, old_in}) begin failures++; $display("FAIL gpio_in_1edge got=%h exp=%h", v, old_in); end
            @(posedge clk);
            @(negedge clk);
            rd(A_GPIO_IN, v);
            checks++; if (v !== {24'b0, new_in}) begin failures++; $display("FAIL gpio_in_2edge got=%h exp=%h", v, new_in); end
            old_in = new_in;
        end
    endtask

    task automatic test_timer();
        logic [31:0] v, c, start;
        for (int it = 0; it < 2; it++) begin
            c = (it == 0) ? 32'd5 : 32'($urandom_range(2, 8));
            wr(A_CTRL, 32'h0);
            wr(A_STATUS, 32'h1);
            wr(A_CMP, c);
            wr(A_TIMER, 32'h0);
            wr(A_CTRL, 32'h3);
            // k = edges since the CTRL write; timer equals k, and match/irq
            // appear at the edge where the timer leaves the value c.
            for (int k = 0; k < int'(c) + 4; k++) begin
                @(negedge clk);
                rd(A_TIMER, v);
                checks++; if (v !== 32'(k)) begin failures++; $display("FAIL timer_count k=%0d got=%h exp=%h", k, v, k); end
                rd(A_STATUS, v);
                checks++; if (v[0] !== (k > int'(c))) begin failures++; $display("FAIL timer_match k=%0d got=%b exp=%b", k, v[0], (k > int'(c))); end
                checks++; if (irq !== (k > int'(c))) begin failures++; $display("FAIL timer_irq k=%0d got=%b exp=%b", k, irq, (k > int'(c))); end
            end
            wr(A_STATUS, 32'h1);
            @(negedge clk);
            rd(A_STATUS, v);
            checks++; if (v[0] !== 1'b0) begin failures++; $display("FAIL match_w1c got=%b exp=0", v[0]); end
            checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_w1c got=%b exp=0", irq); end
        end
        // Wrap without any flag.
        start = 32'hFFFF_FFFD;
        wr(A_TIMER, start);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rd(A_TIMER, v);
            checks++; if (v !== start + 32'(k)) begin failures++; $display("FAIL timer_wrap k=%0d got=%h exp=%h", k, v, start + 32'(k)); end
            rd(A_STATUS, v);
            checks++; if (v[0] !== 1'b0) begin failures++; $display("FAIL wrap_no_match k=%0d got=%b exp=0", k, v[0]); end
        end
        // Match set and W1C land on the same edge: set wins.
        wr(A_CTRL, 32'h0);
        wr(A_TIMER, 32'd100);
        wr(A_CMP, 32'd100);
        wr(A_CTRL, 32'h1);
        wr(A_STATUS, 32'h1);
        @(negedge clk);
        rd(A_STATUS, v);
        checks++; if (v[0] !== 1'b1) begin failures++; $display("FAIL match_set_beats_w1c got=%b exp=1", v[0]); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_disabled got=%b exp=0", irq); end
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);
        @(negedge clk);
        rd(A_STATUS, v);
        checks++; if (v !== 32'h4) begin failures++; $display("FAIL timer_cleanup_status got=%h exp=4", v); end
    endtask

    task automatic test_fifo_fill();
        logic [31:0] v;
        logic [7:0]  b;
        tx_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            b = 8'(8'h11 * (i + 1));
            wr(A_TX_DATA, {24'($urandom), b});
            exp_q.push_back(b);
        end
        @(negedge clk);
        rd(A_STATUS, v);
        checks++; if (v !== 32'h42) begin failures++; $display("FAIL fill_status got=%h exp=42", v); end
        wr(A_TX_DATA, 32'h55);
        @(negedge clk);
        rd(A_STATUS, v);
        checks++; if (v !== 32'h4A) begin failures++; $display("FAIL fill_ovf_status got=%h exp=4a", v); end
        checks++; if (tx_data !== exp_q[0]) begin failures++; $display("FAIL fill_head_stable got=%h exp=%h", tx_data, exp_q[0]); end
        for (int i = 0; i < 4; i++) begin
            tx_ready = 1'b1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin failures++; $display("FAIL fill_drain i=%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_q[0]); end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL fill_empty_valid got=%b exp=0", tx_valid); end
        rd(A_STATUS, v);
        checks++; if (v !== 32'h0C) begin failures++; $display("FAIL fill_empty_status got=%h exp=0c", v); end
        wr(A_STATUS, 32'h8);
        @(negedge clk);
        rd(A_STATUS, v);
        checks++; if (v !== 32'h04) begin failures++; $display("FAIL ovf_w1c got=%h exp=04", v); end
    endtask

    task automatic test_fifo_simultaneous();
        logic [31:0] v;
        logic [7:0]  b;
        tx_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            wr(A_TX_DATA, {24'b0, b});
            exp_q.push_back(b);
        end
        @(negedge clk);
        tx_ready           = 1'b1;
        bus.io_address     = A_TX_DATA;
        bus.io_write_value = 32'h66;
        bus.io_write_en    = 1'b1;
        @(posedge clk);
        #1;
        bus.io_write_en = 1'b0;
        tx_ready        = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'h66);
        @(negedge clk);
        rd(A_STATUS, v);
        checks++; if (v !== 32'h42) begin failures++; $display("FAIL simul_status got=%h exp=42", v); end
        for (int i = 0; i < 4; i++) begin
            tx_ready = 1'b1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin failures++; $display("FAIL simul_drain i=%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_q[0]); end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL simul_empty got=%b exp=0", tx_valid); end
    endtask

    task automatic test_fifo_random();
        logic [31:0] v, exp_status;
        logic [7:0]  b;
        logic        p, r, popped;
        exp_q.delete();
        m_ovf = 1'b0;
        wr(A_STATUS, 32'h8);
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            p = ($urandom_range(0, 2) != 0);
            r = 1'($urandom_range(0, 1));
            b = 8'($urandom);
            checks++; if (tx_valid !== (exp_q.size() > 0)) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, tx_valid, (exp_q.size() > 0)); end
            if (exp_q.size() > 0) begin
                checks++; if (tx_data !== exp_q[0]) begin failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, tx_data, exp_q[0]); end
            end
            if (!p) begin
                exp_status = (32'(exp_q.size()) << 4) | (32'(m_ovf) << 3)
                           | (32'(exp_q.size() == 0) << 2) | (32'(exp_q.size() == DEPTH) << 1);
                rd(A_STATUS, v);
                checks++; if (v !== exp_status) begin failures++; $display("FAIL rand_status cyc=%0d got=%h exp=%h", cyc, v, exp_status); end
            end
            tx_ready = r;
            if (p) begin
                bus.io_address     = A_TX_DATA;
                bus.io_write_value = {24'($urandom), b};
                bus.io_write_en    = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.io_write_en = 1'b0;
            popped = r && (exp_q.size() > 0);
            if (popped) void'(exp_q.pop_front());
            if (p) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(b);
                else m_ovf = 1'b1;
            end
        end
        tx_ready = 1'b1;
        repeat (DEPTH + 1) @(posedge clk);
        @(negedge clk);
        tx_ready = 1'b0;
        exp_q.delete();
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rand_drained got=%b exp=0", tx_valid); end
        wr(A_STATUS, 32'h8);
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        tx_ready = 1'b0;
        wr(A_GPIO_OUT, 32'h5A);
        for (int i = 0; i < 3; i++) wr(A_TX_DATA, 32'($urandom_range(0, 255)));
        wr(A_CMP, 32'd1);
        wr(A_TIMER, 32'd0);
        wr(A_CTRL, 32'h3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (irq !== 1'b1 || tx_valid !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b/%b exp=1/1", irq, tx_valid); end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL arst_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL arst_irq got=%b exp=0", irq); end
        checks++; if (gpio_out !== 8'h00) begin failures++; $display("FAIL arst_gpio_out got=%h exp=00", gpio_out); end
        rd(A_TIMER, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL arst_timer got=%h exp=0", v); end
        rd(A_STATUS, v);
        checks++; if (v !== 32'h4) begin failures++; $display("FAIL arst_status got=%h exp=4", v); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd(A_TIMER, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL arst_post_timer got=%h exp=0", v); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL arst_post_valid got=%b exp=0", tx_valid); end
    endtask

    initial begin
        bus.io_address     = '0;
        bus.io_write_value = '0;
        bus.io_write_en    = 1'b0;
        bus.io_read_en     = 1'b0;
        test_reset();
        test_gpio();
        test_timer();
        test_fifo_fill();
        test_fifo_simultaneous();
        test_fifo_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
